// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of a 1-cycle registered-read ROM (IDLE/READ/WAIT).
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module rom_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   win;
  logic   take;

  assign take = (state == IDLE) && (req0 || req1);

`ifdef ROM_ARB_FIXED_PRIO_EN
  assign win = !req0;
`else
  logic last;
  // On a tie, favour whoever was not granted last.
  assign win = (req0 && req1) ? !last : req1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last <= 1'b1;
    else if (take) last <= win;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = READ;
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    busy = (state != IDLE);
    if (state == READ) begin
      gnt0 = !owner;
      gnt1 = owner;
    end
  end

  // Address and owner are latched at grant so later bus changes cannot disturb the read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
      owner    <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      if (take) begin
        rom_addr <= win ? addr1 : addr0;
        owner    <= win;
      end
      rvalid0 <= (state == WAIT) && !owner;
      rvalid1 <= (state == WAIT) &&  owner;
      if (state == WAIT && !owner) rdata0 <= rom_data;
      if (state == WAIT &&  owner) rdata1 <= rom_data;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed table-driven bench for rom_arbiter with a rom[a] = ~a registered-read model.
module tb_rom_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [7:0] rdata0, rdata1, rom_addr;
  logic [7:0] rom_data = '0;

  int errors = 0;
  int checks = 0;
  logic [7:0] rd0_m = '0, rd1_m = '0;

  rom_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= ~rom_addr;

  typedef struct {
    logic       r0;
    logic [7:0] a0;
    logic       r1;
    logic [7:0] a1;
    logic       own;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Control outputs packed as {gnt0,gnt1,rvalid0,rvalid1,busy}, plus both rdata registers.
  task automatic cyc(input string name, input logic [4:0] exp);
    chk({name, " ctl"}, {27'd0, gnt0, gnt1, rvalid0, rvalid1, busy}, {27'd0, exp});
    chk({name, " rdata"}, {16'd0, rdata0, rdata1}, {16'd0, rd0_m, rd1_m});
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the rvalid cycle.
  task automatic txn(input string name, input logic r0, input logic [7:0] a0,
                     input logic r1, input logic [7:0] a1,
                     input logic own, input logic [7:0] dat);
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    @(negedge clk);
    cyc({name, " read"}, own ? 5'b01001 : 5'b10001);
    @(negedge clk);
    cyc({name, " wait"}, 5'b00001);
    @(negedge clk);
    if (own) rd1_m = dat; else rd0_m = dat;
    cyc({name, " rvalid"}, own ? 5'b00010 : 5'b00100);
  endtask

  initial begin
`ifdef ROM_ARB_FIXED_PRIO_EN
    vecs[0]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 8'hFE};
    vecs[1]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 8'hFE};
    vecs[2]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 8'hFE};
    vecs[3]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 8'hFE};
    vecs[11] = '{1'b1, 8'h55, 1'b1, 8'h66, 1'b0, 8'hAA};
    vecs[12] = '{1'b1, 8'h55, 1'b1, 8'h66, 1'b0, 8'hAA};
`else
    vecs[0]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 8'hFE};
    vecs[1]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 8'hFD};
    vecs[2]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 8'hFE};
    vecs[3]  = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 8'hFD};
    vecs[11] = '{1'b1, 8'h55, 1'b1, 8'h66, 1'b0, 8'hAA};
    vecs[12] = '{1'b1, 8'h55, 1'b1, 8'h66, 1'b1, 8'h99};
`endif
    vecs[4]  = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 8'hEF};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFF};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'hFE};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'hFD};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'hFC};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'hFB};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'hFA};
    vecs[13] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset outputs", {8'd0, gnt0, gnt1, rvalid0, rvalid1, busy, 3'd0, rdata0, rdata1, rom_addr},
        32'd0);
    reset_n = 1'b1;

    // Back-to-back vectors: each starts at the rvalid negedge of the previous one.
    for (int i = 0; i < 14; i++)
      txn($sformatf("vec%0d", i), vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1,
          vecs[i].own, vecs[i].dat);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    cyc("idle after vecs", 5'b00000);

    // Requester 1 waits behind owner 0 while its address bus changes.
    req0 = 1'b1; addr0 = 8'h12;
    @(negedge clk);
    cyc("chg read", 5'b10001);
    req0 = 1'b0; req1 = 1'b1; addr1 = 8'h33;
    @(negedge clk);
    cyc("chg wait", 5'b00001);
    chk("chg rom_addr hold", {24'd0, rom_addr}, 32'h12);
    addr1 = 8'h44;
    @(negedge clk);
    rd0_m = 8'hED;
    cyc("chg rvalid0", 5'b00100);
    @(negedge clk);
    cyc("chg read1", 5'b01001);
    chk("chg rom_addr1", {24'd0, rom_addr}, 32'h44);
    req1 = 1'b0;
    @(negedge clk);
    cyc("chg wait1", 5'b00001);
    @(negedge clk);
    rd1_m = 8'hBB;
    cyc("chg rvalid1", 5'b00010);

    // Reset pulsed during WAIT aborts the read.
    req0 = 1'b1; addr0 = 8'h20;
    @(negedge clk);
    cyc("rst read", 5'b10001);
    req0 = 1'b0;
    @(negedge clk);
    cyc("rst wait", 5'b00001);
    reset_n = 1'b0;
    #1;
    chk("rst immediate", {8'd0, gnt0, gnt1, rvalid0, rvalid1, busy, 3'd0, rdata0, rdata1, rom_addr},
        32'd0);
    rd0_m = '0; rd1_m = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cyc($sformatf("rst post%0d", i), 5'b00000);
    end
    // Tie after reset goes to requester 0 in both builds.
    txn("rst next", 1'b1, 8'h21, 1'b1, 8'h22, 1'b0, 8'hDE);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    cyc("final idle", 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Mutual exclusion on grants and valids, sampled every negedge.
  always @(negedge clk) begin
    if (gnt0 && gnt1) begin
      errors++;
      $display("FAIL gnt excl: gnt0=%b gnt1=%b required not both", gnt0, gnt1);
    end
    if (rvalid0 && rvalid1) begin
      errors++;
      $display("FAIL rvalid excl: rvalid0=%b rvalid1=%b required not both", rvalid0, rvalid1);
    end
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, ROM address width.
REQ-002 Parameter DATA_W, default 8, ROM data width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req0  input  1  requester 0 read request; held high until gnt0 seen.
REQ-006 addr0  input  ADDR_W  requester 0 address; stable while req0 high.
REQ-007 gnt0  output  1  one-cycle pulse: requester 0 address issued to ROM.
REQ-008 rdata0  output  DATA_W  requester 0 read data, registered.
REQ-009 rvalid0  output  1  one-cycle pulse: rdata0 valid.
REQ-010 req1, addr1, gnt1, rdata1, rvalid1: same as REQ-005..009 for requester 1.
REQ-011 rom_addr  output  ADDR_W  registered address to synchronous ROM (1-cycle registered read).
REQ-012 rom_data  input  DATA_W  ROM read data, valid the cycle after rom_addr is sampled.
REQ-013 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 FSM shall have exactly three states: IDLE, READ, WAIT.
REQ-015 IDLE: at a clock edge with req0 or req1 high, select winner, load rom_addr with winner's address, latch owner, go READ; else stay IDLE.
REQ-016 READ: gnt of owner high this cycle only; ROM samples rom_addr at end of cycle; unconditionally go WAIT.
REQ-017 WAIT: at end of cycle capture rom_data into owner's rdata register, pulse owner's rvalid for the following cycle, go IDLE.
REQ-018 Latency: req sampled at edge E -> gnt high cycle E+1 -> rvalid high cycle E+3; max throughput one read per 3 cycles.
REQ-019 Requests sampled only in IDLE; req held high in IDLE the cycle rvalid is high is a new request.
REQ-020 Arbitration round-robin: both requesting -> grant requester not granted last; single requester always granted.
REQ-021 last-grant pointer updates only on grant; non-owner's rdata holds its previous value.
REQ-022 gnt0/gnt1 never high together; rvalid0/rvalid1 never high together.
REQ-023 rom_addr holds its value outside IDLE->READ transitions.
REQ-024 Address changes on a waiting requester's addr bus before grant shall not affect an in-flight read.

Reset
REQ-025 reset_n low shall immediately force: state IDLE, gnt0/gnt1/rvalid0/rvalid1/busy 0, rdata0/rdata1/rom_addr 0, last-grant pointer = requester 1 (requester 0 wins first tie).
REQ-026 Reset during READ or WAIT shall abort the transaction; no rvalid issued after reset release.
REQ-027 First request sampled on the first rising edge with reset_n high.

Configuration
REQ-028 Macro ROM_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins ties, last-grant pointer absent.
REQ-029 Macro undefined: round-robin per REQ-020; all other behaviour identical.

Verification (ROM model: rom[a] = ~a, 1-cycle registered read)
REQ-030 req0=1, addr0=0x10 alone -> gnt0 one cycle after sample, rvalid0 two cycles later, rdata0=0xEF; gnt1/rvalid1 stay 0.
REQ-031 req0 and req1 held high, addr0=0x01, addr1=0x02, four grants -> order 0,1,0,1; rdata0=0xFE, rdata1=0xFD; (fixed-prio build: all grants to 0 until req0 dropped).
REQ-032 req1 continuously high, addr1 stepping 0x00..0x05 after each gnt1 -> one rvalid1 every 3 cycles, rdata1 = 0xFF..0xFA in order.
REQ-033 reset_n pulsed low during WAIT of read addr0=0x20 -> no rvalid0, all outputs 0, busy 0; next request serviced normally.
REQ-034 addr1 changed 0x33->0x44 while req1 waits behind owner 0 -> in-flight rdata0 unaffected; rdata1=0xBB (~0x44).
REQ-035 busy high exactly in READ and WAIT cycles; low in cycle rvalid is high.
